mips16_mc_ctrl: RTL
===================

MIPS16_MC_CTRL -- requirements
Module: mips16_mc_ctrl

Interface
REQ-001 SHALL have ports, clock and reset first: clk in 1 (single clock, rising edge); rst in 1 (asynchronous, active-high).
REQ-002 SHALL have ports: opcode in 4 (instruction bits [15:12] from IR); zero in 1 (ALU zero flag); mem_ready in 1 (memory completion).
REQ-003 SHALL have ports: mem_req out 1; mem_we out 1; ir_write out 1; pc_write out 1; reg_write out 1.
REQ-004 SHALL have ports: alu_src_a out 1 (MUX2 select: 0=PC, 1=regA); alu_src_b out 2 (MUX4 select: 00=regB, 01=const 1, 10=sign-ext imm, 11=branch offset).
REQ-005 SHALL have ports: pc_src out 2 (MUX3 select: 00=ALU result, 01=ALUOut reg, 10=jump target); wb_src out 1 (MUX2 select: 0=ALUOut, 1=MDR).
REQ-006 SHALL have ports: alu_op out 2 (00=add, 01=sub, 10=funct); halted out 1; illegal out 1 (sticky).

Function
REQ-007 SHALL decode opcodes: 0000 R-type, 0001 ADDI, 0010 LW, 0011 SW, 0100 BEQ, 0101 J, 1111 HALT; all others illegal.
REQ-008 SHALL implement states: FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JUMP, HALT.
REQ-009 SHALL in FETCH assert mem_req, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00; hold until mem_ready=1, then pulse ir_write and pc_write in that same cycle and go to DECODE.
REQ-010 SHALL in DECODE compute branch target (alu_src_a=0, alu_src_b=11, alu_op=00), then transition: R->EXEC_R, ADDI->EXEC_I, LW/SW->ADDR, BEQ->BRANCH, J->JUMP, HALT->HALT, illegal->FETCH with illegal set.
REQ-011 SHALL in EXEC_R drive alu_src_a=1, alu_src_b=00, alu_op=10, then go to WB_ALU.
REQ-012 SHALL in EXEC_I and ADDR drive alu_src_a=1, alu_src_b=10, alu_op=00; EXEC_I->WB_ALU, ADDR->MEM_RD (LW) or MEM_WR (SW).
REQ-013 SHALL in MEM_RD assert mem_req (mem_we=0) until mem_ready, then go to WB_MEM.
REQ-014 SHALL in MEM_WR assert mem_req and mem_we until mem_ready, then go to FETCH.
REQ-015 SHALL in WB_ALU assert reg_write with wb_src=0, and in WB_MEM with wb_src=1, each for exactly one cycle, then go to FETCH.
REQ-016 SHALL in BRANCH drive alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_write=zero (same-cycle), then go to FETCH.
REQ-017 SHALL in JUMP drive pc_src=10, pc_write=1 for one cycle, then go to FETCH.
REQ-018 SHALL in HALT remain until reset with halted=1 and all write/request outputs 0.
REQ-019 SHALL deassert ir_write, pc_write, reg_write, mem_req, mem_we in every state/condition not listed above; unlisted selects drive 0.
REQ-020 SHALL give cycle counts with mem_ready tied 1: R/ADDI 4, LW 5, SW 4, BEQ 3, J 3; each memory wait cycle adds one.
REQ-021 SHALL ignore mem_ready outside FETCH, MEM_RD, MEM_WR.
REQ-022 SHALL keep illegal set until reset; execution continues with the next fetch.

Reset
REQ-023 SHALL on rst=1 asynchronously enter FETCH, clear illegal and halted, and force all outputs to 0 while rst is held.
REQ-024 SHALL abort any in-flight access on rst mid-operation (mem_req drops immediately) and refetch after rst deasserts.

Structure
REQ-025 SHALL place state encoding, opcode constants and all select encodings (ALU-A, ALU-B, PC-source, WB-source, alu_op) in shared package mips16_ctrl_pkg.
REQ-026 SHALL split into a registered next-state core and one combinational sub-module mips16_ctrl_decode mapping (state, zero, mem_ready) to outputs.

Verification
REQ-027 SHALL cover R-type with mem_ready=1: states FETCH,DECODE,EXEC_R,WB_ALU; reg_write=1, wb_src=0 in cycle 4 only.
REQ-028 SHALL cover LW with 2 wait cycles in MEM_RD: mem_req held 3 cycles, reg_write with wb_src=1 at cycle 7.
REQ-029 SHALL cover BEQ: zero=1 -> pc_write=1, pc_src=01 in BRANCH; zero=0 -> pc_write=0; both return to FETCH.
REQ-030 SHALL cover opcode 1010 -> illegal=1 after DECODE, next state FETCH; then 1111 -> halted=1 held for 10+ cycles.
REQ-031 SHALL cover rst asserted mid-MEM_WR with mem_ready=0: mem_req/mem_we drop asynchronously; after release, FETCH with mem_req=1.

Source files
------------

// File: rtl/mips16_ctrl_pkg.sv
// rtl/mips16_ctrl_pkg.sv - shared encodings and control-word type for the MIPS16 multicycle controller
package mips16_ctrl_pkg;

  // Controller states; FETCH is the reset state so it is pinned to zero.
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_EXEC_I = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_MEM_WR = 4'd6,
    S_WB_ALU = 4'd7,
    S_WB_MEM = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_HALT   = 4'd11
  } state_t;

  // Instruction opcodes (IR[15:12]).
  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0001;
  localparam logic [3:0] OP_LW    = 4'b0010;
  localparam logic [3:0] OP_SW    = 4'b0011;
  localparam logic [3:0] OP_BEQ   = 4'b0100;
  localparam logic [3:0] OP_J     = 4'b0101;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  // ALU A-input mux.
  localparam logic ALU_A_PC  = 1'b0;
  localparam logic ALU_A_REG = 1'b1;

  // ALU B-input mux.
  localparam logic [1:0] ALU_B_REG  = 2'b00;
  localparam logic [1:0] ALU_B_ONE  = 2'b01;
  localparam logic [1:0] ALU_B_IMM  = 2'b10;
  localparam logic [1:0] ALU_B_BOFF = 2'b11;

  // PC source mux.
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // Register write-back source mux.
  localparam logic WB_SRC_ALUOUT = 1'b0;
  localparam logic WB_SRC_MDR    = 1'b1;

  // ALU operation class.
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  // Full control word produced each cycle by the decoder.
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       wb_src;
    logic [1:0] alu_op;
    logic       halted;
  } ctrl_t;

  // Everything deasserted, every select at its zero encoding.
  localparam ctrl_t CTRL_IDLE = '0;

  // True for the seven opcodes the datapath understands.
  function automatic logic op_is_legal(input logic [3:0] op);
    case (op)
      OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_HALT: op_is_legal = 1'b1;
      default:                                                op_is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips16_ctrl_decode.sv
// rtl/mips16_ctrl_decode.sv - combinational map from controller state to datapath control outputs
module mips16_ctrl_decode
  import mips16_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       wb_src,
  output logic [1:0] alu_op,
  output logic       halted
);

  ctrl_t c;

  // Per-state control word; anything a state does not mention stays idle/zero.
  always_comb begin
    c = CTRL_IDLE;
    case (state)
      S_FETCH: begin
        // PC+1 is computed every fetch cycle; IR and PC only latch once memory answers.
        c.mem_req   = 1'b1;
        c.alu_src_a = ALU_A_PC;
        c.alu_src_b = ALU_B_ONE;
        c.alu_op    = ALU_OP_ADD;
        c.pc_src    = PC_SRC_ALU;
        c.ir_write  = mem_ready;
        c.pc_write  = mem_ready;
      end
      S_DECODE: begin
        // Speculative branch target into ALUOut while registers are read.
        c.alu_src_a = ALU_A_PC;
        c.alu_src_b = ALU_B_BOFF;
        c.alu_op    = ALU_OP_ADD;
      end
      S_EXEC_R: begin
        c.alu_src_a = ALU_A_REG;
        c.alu_src_b = ALU_B_REG;
        c.alu_op    = ALU_OP_FUNCT;
      end
      S_EXEC_I, S_ADDR: begin
        c.alu_src_a = ALU_A_REG;
        c.alu_src_b = ALU_B_IMM;
        c.alu_op    = ALU_OP_ADD;
      end
      S_MEM_RD: begin
        c.mem_req = 1'b1;
      end
      S_MEM_WR: begin
        c.mem_req = 1'b1;
        c.mem_we  = 1'b1;
      end
      S_WB_ALU: begin
        c.reg_write = 1'b1;
        c.wb_src    = WB_SRC_ALUOUT;
      end
      S_WB_MEM: begin
        c.reg_write = 1'b1;
        c.wb_src    = WB_SRC_MDR;
      end
      S_BRANCH: begin
        // Compare regA-regB; take the ALUOut target only when equal.
        c.alu_src_a = ALU_A_REG;
        c.alu_src_b = ALU_B_REG;
        c.alu_op    = ALU_OP_SUB;
        c.pc_src    = PC_SRC_ALUOUT;
        c.pc_write  = zero;
      end
      S_JUMP: begin
        c.pc_src   = PC_SRC_JUMP;
        c.pc_write = 1'b1;
      end
      S_HALT: begin
        c.halted = 1'b1;
      end
      default: begin
        c = CTRL_IDLE;
      end
    endcase
  end

  assign mem_req   = c.mem_req;
  assign mem_we    = c.mem_we;
  assign ir_write  = c.ir_write;
  assign pc_write  = c.pc_write;
  assign reg_write = c.reg_write;
  assign alu_src_a = c.alu_src_a;
  assign alu_src_b = c.alu_src_b;
  assign pc_src    = c.pc_src;
  assign wb_src    = c.wb_src;
  assign alu_op    = c.alu_op;
  assign halted    = c.halted;

endmodule

// File: rtl/mips16_mc_ctrl.sv
// rtl/mips16_mc_ctrl.sv - multicycle MIPS16 control unit: state register, sequencing and sticky illegal flag
module mips16_mc_ctrl
  import mips16_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       wb_src,
  output logic [1:0] alu_op,
  output logic       halted,
  output logic       illegal
);

  state_t     state;
  state_t     state_next;
  logic       illegal_q;
  logic       illegal_set;

  logic       dec_mem_req;
  logic       dec_mem_we;
  logic       dec_ir_write;
  logic       dec_pc_write;
  logic       dec_reg_write;
  logic       dec_alu_src_a;
  logic [1:0] dec_alu_src_b;
  logic [1:0] dec_pc_src;
  logic       dec_wb_src;
  logic [1:0] dec_alu_op;
  logic       dec_halted;

  // State register; reset drops straight back to FETCH, abandoning any access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Sticky illegal-opcode flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else if (illegal_set) begin
      illegal_q <= 1'b1;
    end
  end

  // An unknown opcode is only noticed while decoding it.
  always_comb begin
    illegal_set = (state == S_DECODE) && !op_is_legal(opcode);
  end

  // Next-state sequencing; mem_ready only matters in the three memory states.
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH: begin
        if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_next = S_EXEC_R;
          OP_ADDI:      state_next = S_EXEC_I;
          OP_LW, OP_SW: state_next = S_ADDR;
          OP_BEQ:       state_next = S_BRANCH;
          OP_J:         state_next = S_JUMP;
          OP_HALT:      state_next = S_HALT;
          default:      state_next = S_FETCH;
        endcase
      end
      S_EXEC_R: state_next = S_WB_ALU;
      S_EXEC_I: state_next = S_WB_ALU;
      S_ADDR: begin
        // IR is stable here, so the opcode still selects load vs store.
        state_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        if (mem_ready) state_next = S_WB_MEM;
      end
      S_MEM_WR: begin
        if (mem_ready) state_next = S_FETCH;
      end
      S_WB_ALU: state_next = S_FETCH;
      S_WB_MEM: state_next = S_FETCH;
      S_BRANCH: state_next = S_FETCH;
      S_JUMP:   state_next = S_FETCH;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_FETCH;
    endcase
  end

  mips16_ctrl_decode u_decode (
    .state     (state),
    .zero      (zero),
    .mem_ready (mem_ready),
    .mem_req   (dec_mem_req),
    .mem_we    (dec_mem_we),
    .ir_write  (dec_ir_write),
    .pc_write  (dec_pc_write),
    .reg_write (dec_reg_write),
    .alu_src_a (dec_alu_src_a),
    .alu_src_b (dec_alu_src_b),
    .pc_src    (dec_pc_src),
    .wb_src    (dec_wb_src),
    .alu_op    (dec_alu_op),
    .halted    (dec_halted)
  );

  // Output stage: force everything low for as long as reset is held.
  always_comb begin
    if (rst) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
      alu_src_a = 1'b0;
      alu_src_b = 2'b00;
      pc_src    = 2'b00;
      wb_src    = 1'b0;
      alu_op    = 2'b00;
      halted    = 1'b0;
      illegal   = 1'b0;
    end else begin
      mem_req   = dec_mem_req;
      mem_we    = dec_mem_we;
      ir_write  = dec_ir_write;
      pc_write  = dec_pc_write;
      reg_write = dec_reg_write;
      alu_src_a = dec_alu_src_a;
      alu_src_b = dec_alu_src_b;
      pc_src    = dec_pc_src;
      wb_src    = dec_wb_src;
      alu_op    = dec_alu_op;
      halted    = dec_halted;
      illegal   = illegal_q;
    end
  end

endmodule
